// File: rtl/gen_stream_collector.sv
// Consumer for a start/ready/valid/done generator core: launches a run, buffers every yield in a
// small FWFT FIFO and replays it on a valid/ready stream, then reports the yield count.
module gen_stream_collector #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    __clock,
  input  logic                    __reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [WIDTH-1:0] cmd_arg,
  output logic                    gen_start,
  output logic signed [WIDTH-1:0] gen_arg,
  output logic                    gen_ready,
  input  logic                    gen_valid,
  input  logic                    gen_done,
  input  logic signed [WIDTH-1:0] gen_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    run_done,
  output logic [CNT_W-1:0]        run_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StFlush} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic [CNT_W-1:0]        yield_q;
  logic signed [WIDTH-1:0] arg_q;

  logic accept, push, pop, gen_fin;

  assign accept  = cmd_valid && cmd_ready;
  assign push    = gen_valid && gen_ready;
  assign gen_fin = gen_done && gen_ready;
  assign pop     = out_valid && out_ready;

  // State register
  always_ff @(posedge __clock) begin
    if (__reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (gen_fin) state_d = StFlush;
      StFlush: if (run_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; gen_ready comes from the registered count so a pop at full reopens next cycle
  always_comb begin
    cmd_ready = 1'b0;
    gen_start = 1'b0;
    gen_ready = 1'b0;
    run_done  = 1'b0;
    unique case (state_q)
      StIdle:  cmd_ready = 1'b1;
      StStart: gen_start = 1'b1;
      StRun:   gen_ready = (count_q < FullCount);
      StFlush: run_done  = (count_q == '0) || ((count_q == (AW + 1)'(1)) && pop);
      default: ;
    endcase
    run_count = run_done ? yield_q : '0;
  end

  assign gen_arg   = arg_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Run bookkeeping: argument latch and saturating yield counter
  always_ff @(posedge __clock) begin
    if (__reset) begin
      arg_q   <= '0;
      yield_q <= '0;
    end else if (accept) begin
      arg_q   <= cmd_arg;
      yield_q <= '0;
    end else if (push && (yield_q != '1)) begin
      yield_q <= yield_q + CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge __clock) begin
    if (__reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge __clock) begin
    if (push) mem_q[wr_ptr_q] <= gen_data;
  end

endmodule

// File: tb/tb_gen_stream_collector.sv
// Bench for gen_stream_collector: a behavioural generator model plus an ordered data scoreboard.
module tb_gen_stream_collector;

  localparam int W  = 32;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid, cmd_ready;
  logic signed [W-1:0] cmd_arg;
  logic                gen_start, gen_ready;
  logic signed [W-1:0] gen_arg;
  logic                gen_valid = 1'b0, gen_done = 1'b0;
  logic signed [W-1:0] gen_data = '0;
  logic                out_valid, out_ready;
  logic signed [W-1:0] out_data;
  logic                run_done;
  logic [CW-1:0]       run_count;

  gen_stream_collector #(.WIDTH(W), .DEPTH(4), .CNT_W(CW)) dut (
    .__clock  (clk),
    .__reset  (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_arg  (cmd_arg),
    .gen_start(gen_start),
    .gen_arg  (gen_arg),
    .gen_ready(gen_ready),
    .gen_valid(gen_valid),
    .gen_done (gen_done),
    .gen_data (gen_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .run_done (run_done),
    .run_count(run_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic signed [W-1:0] exp_q[$];
  logic signed [W-1:0] gen_list[$];
  int                  run_lens[$];
  int                  cur_left = 0;
  bit                  gen_active = 0, gen_fire = 0, coincide = 0;
  int                  start_cycles = 0;
  logic signed [W-1:0] start_arg = '0;

  // Generator model: decides at negedge what it presents for the next posedge
  always @(negedge clk) begin
    if (rst) begin
      gen_active = 0;
      gen_fire   = 0;
      gen_valid  = 1'b0;
      gen_done   = 1'b0;
      gen_data   = '0;
    end else begin
      if (gen_fire) begin
        if (gen_valid) begin
          void'(gen_list.pop_front());
          cur_left--;
        end
        if (gen_done) gen_active = 0;
      end
      if (gen_start) begin
        start_cycles++;
        start_arg  = gen_arg;
        gen_active = 1;
        if (run_lens.size() > 0) cur_left = run_lens.pop_front();
        else cur_left = 0;
      end
      gen_valid = gen_active && (cur_left > 0);
      gen_done  = gen_active && ((cur_left == 0) || (coincide && cur_left == 1));
      if (gen_valid) gen_data = gen_list[0];
      else gen_data = '0;
      gen_fire = (gen_valid || gen_done) && gen_ready;
    end
  end

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_arg = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready);
    else passed++;
    checks++; if (gen_start !== 1'b0) $display("FAIL rst_gen_start got %b exp 0", gen_start);
    else passed++;
    checks++; if (gen_arg !== '0) $display("FAIL rst_gen_arg got %0d exp 0", gen_arg);
    else passed++;
    checks++; if (gen_ready !== 1'b0) $display("FAIL rst_gen_ready got %b exp 0", gen_ready);
    else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid);
    else passed++;
    checks++; if (out_data !== '0) $display("FAIL rst_out_data got %0d exp 0", out_data);
    else passed++;
    checks++; if (run_done !== 1'b0) $display("FAIL rst_run_done got %b exp 0", run_done);
    else passed++;
    checks++; if (run_count !== '0) $display("FAIL rst_run_count got %0d exp 0", run_count);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit done = 0;
    int pops = 0;
    start_cycles = 0; coincide = 0; out_ready = 1'b1;
    gen_list = '{1, 1, 3, 5}; run_lens.push_back(4); exp_q = '{1, 1, 3, 5};
    @(negedge clk); cmd_arg = 10; cmd_valid = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL basic_cmd_ready got %b exp 1", cmd_ready);
    else passed++;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL basic_data got %0d exp none", out_data);
        else begin
          if (out_data !== exp_q[0]) $display("FAIL basic_data got %0d exp %0d", out_data, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
        pops++;
      end
      if (run_done) begin
        done = 1;
        checks++; if (run_count !== 16'd4) $display("FAIL basic_count got %0d exp 4", run_count);
        else passed++;
        checks++; if (pops !== 4) $display("FAIL basic_done_after_pops got %0d exp 4", pops);
        else passed++;
      end
    end
    checks++; if (done !== 1'b1) $display("FAIL basic_timeout got no run_done exp run_done");
    else passed++;
    checks++; if (start_cycles !== 1) $display("FAIL basic_start_len got %0d exp 1", start_cycles);
    else passed++;
    checks++; if (start_arg !== 10) $display("FAIL basic_start_arg got %0d exp 10", start_arg);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (run_done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL basic_after_done got done=%b rdy=%b exp done=0 rdy=1", run_done, cmd_ready);
    else passed++;
    checks++; if (gen_arg !== 10) $display("FAIL basic_arg_hold got %0d exp 10", gen_arg);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit done = 0;
    bit stall_ok = 1;
    int pushes = 0;
    int pops = 0;
    out_ready = 1'b0;
    gen_list = '{1, 1, 3, 5}; run_lens.push_back(4); exp_q = '{1, 1, 3, 5};
    @(negedge clk); cmd_arg = 10; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 50 && pushes < 4; c++) begin
      @(negedge clk); #1;
      if (gen_valid && gen_ready) pushes++;
    end
    checks++; if (pushes !== 4) $display("FAIL bp_pushes got %0d exp 4", pushes);
    else passed++;
    @(negedge clk); #1;
    checks++; if (gen_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", gen_ready);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (gen_ready !== 1'b0 || gen_done !== 1'b1 || run_done !== 1'b0 || out_valid !== 1'b1)
        stall_ok = 0;
    end
    checks++; if (stall_ok !== 1'b1) $display("FAIL bp_stall got broken stall exp held");
    else passed++;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_data got %0d exp none", out_data);
        else begin
          if (out_data !== exp_q[0]) $display("FAIL bp_data got %0d exp %0d", out_data, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
        pops++;
      end
      if (run_done) begin
        done = 1;
        checks++; if (run_count !== 16'd4) $display("FAIL bp_count got %0d exp 4", run_count);
        else passed++;
      end
    end
    checks++;
    if (done !== 1'b1 || pops !== 4) $display("FAIL bp_drain got pops=%0d done=%b exp 4,1", pops, done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_done_with_valid();
    bit done = 0;
    bit both_seen = 0;
    coincide = 1; out_ready = 1'b1;
    gen_list = '{2, -7}; run_lens.push_back(2); exp_q = '{2, -7};
    @(negedge clk); cmd_arg = 3; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      if (gen_valid && gen_done && gen_ready) both_seen = 1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL dv_data got %0d exp none", out_data);
        else begin
          if (out_data !== exp_q[0]) $display("FAIL dv_data got %0d exp %0d", out_data, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
      end
      if (run_done) begin
        done = 1;
        checks++; if (run_count !== 16'd2) $display("FAIL dv_count got %0d exp 2", run_count);
        else passed++;
      end
    end
    checks++;
    if (done !== 1'b1 || both_seen !== 1'b1 || exp_q.size() !== 0)
      $display("FAIL dv_end got done=%b both=%b left=%0d exp 1,1,0", done, both_seen, exp_q.size());
    else passed++;
    coincide = 0;
    @(negedge clk);
  endtask

  task automatic test_zero_yield();
    bit done = 0;
    bit seen_valid = 0;
    out_ready = 1'b1;
    run_lens.push_back(0);
    @(negedge clk); cmd_arg = 0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen_valid = 1;
      if (run_done) begin
        done = 1;
        checks++; if (run_count !== 16'd0) $display("FAIL zero_count got %0d exp 0", run_count);
        else passed++;
      end
    end
    checks++;
    if (done !== 1'b1 || seen_valid !== 1'b0)
      $display("FAIL zero_run got done=%b valid_seen=%b exp 1,0", done, seen_valid);
    else passed++;
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL zero_cmd_ready got %b exp 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit done = 0;
    bit early_done = 0;
    int pushes = 0;
    out_ready = 1'b0;
    gen_list = '{1, 1, 3, 5}; run_lens.push_back(4); exp_q = '{1, 1, 3, 5};
    @(negedge clk); cmd_arg = 10; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 50 && pushes < 2; c++) begin
      @(negedge clk); #1;
      if (gen_valid && gen_ready) pushes++;
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL rmr_pre_valid got %b exp 1", out_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || gen_ready !== 1'b0 || run_done !== 1'b0)
      $display("FAIL rmr_abort got v=%b r=%b d=%b exp 0,0,0", out_valid, gen_ready, run_done);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    gen_list.delete(); run_lens.delete(); exp_q.delete();
    gen_list = '{1, 1, 3, 5}; run_lens.push_back(4); exp_q = '{1, 1, 3, 5};
    out_ready = 1'b1;
    @(negedge clk); cmd_arg = 10; cmd_valid = 1'b1; #1;
    if (run_done) early_done = 1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rmr_data got %0d exp none", out_data);
        else begin
          if (out_data !== exp_q[0]) $display("FAIL rmr_data got %0d exp %0d", out_data, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
      end
      if (run_done) begin
        done = 1;
        checks++; if (run_count !== 16'd4) $display("FAIL rmr_count got %0d exp 4", run_count);
        else passed++;
      end
    end
    checks++;
    if (done !== 1'b1 || early_done !== 1'b0)
      $display("FAIL rmr_rerun got done=%b early=%b exp 1,0", done, early_done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int pops = 0;
    int accepts = 0;
    int exp_cnt;
    int exp_pops;
    start_cycles = 0; out_ready = 1'b1;
    gen_list = '{11, 12, 13, 21, 22}; run_lens = '{3, 2}; exp_q = '{11, 12, 13, 21, 22};
    @(negedge clk); cmd_arg = 30; cmd_valid = 1'b1;
    for (int c = 0; c < 200 && dones < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (accepts == 1) cmd_arg = 31;
      if (accepts == 2) cmd_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) begin
        accepts++;
        if (accepts == 2) begin
          checks++; if (dones < 1) $display("FAIL b2b_early_accept got dones=%0d exp >=1", dones);
          else passed++;
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_data got %0d exp none", out_data);
        else begin
          if (out_data !== exp_q[0]) $display("FAIL b2b_data got %0d exp %0d", out_data, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
        pops++;
      end
      if (run_done) begin
        dones++;
        exp_cnt  = (dones == 1) ? 3 : 2;
        exp_pops = (dones == 1) ? 3 : 5;
        checks++;
        if (run_count !== CW'(exp_cnt) || pops !== exp_pops)
          $display("FAIL b2b_run%0d got cnt=%0d pops=%0d exp %0d,%0d",
                   dones, run_count, pops, exp_cnt, exp_pops);
        else passed++;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (dones !== 2 || start_cycles !== 2 || start_arg !== 31)
      $display("FAIL b2b_end got dones=%0d starts=%0d arg=%0d exp 2,2,31",
               dones, start_cycles, start_arg);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_arg = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_done_with_valid();
    test_zero_yield();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
